// File: rtl/ahb_lite_slave_mem.sv
// AHB-Lite slave backed by a word-addressed memory with optional wait states.
// Define AHB_SLAVE_ERR_EN to answer out-of-range, oversized or unaligned transfers with ERROR.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif

module ahb_lite_slave_mem #(
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  HSEL,
    input  logic [`BUS_WIDTH-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    input  logic [`BUS_WIDTH-1:0] HWDATA,
    output logic [`BUS_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int unsigned BYTES     = `BUS_WIDTH / 8;
    localparam int unsigned LANE_BITS = $clog2(BYTES);
    localparam int unsigned IDX_BITS  = $clog2(MEM_DEPTH);
    localparam logic [3:0]  WS_LOAD   = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2} state_t;

    state_t                  state, state_next;
    logic [3:0]              wait_cnt, wait_cnt_next;
    logic [IDX_BITS-1:0]     idx_q;
    logic [LANE_BITS-1:0]    off_q;
    logic [2:0]              size_q;
    logic                    write_q;
    logic [`BUS_WIDTH-1:0]   mem [MEM_DEPTH];

    logic                    accept, addr_err, rd_load, commit;
    logic [IDX_BITS-1:0]     haddr_idx, rd_idx;
    logic [BYTES-1:0]        wr_mask;
    logic [`BUS_WIDTH-1:0]   wr_word, rd_word;

    // Lanes sharing the size-aligned block that contains the offset; this also aligns down.
    function automatic logic [BYTES-1:0] lane_mask(input logic [LANE_BITS-1:0] off,
                                                   input logic [2:0] size);
        logic [BYTES-1:0] m;
        int unsigned      sz;
        m  = '0;
        sz = (32'(size) > LANE_BITS) ? LANE_BITS : 32'(size);
        for (int unsigned i = 0; i < BYTES; i++) begin
            if ((i >> sz) == (32'(off) >> sz)) m[i] = 1'b1;
        end
        return m;
    endfunction

    assign haddr_idx = HADDR[LANE_BITS +: IDX_BITS];
    assign HREADYOUT = (state != S_WAIT) && (state != S_ERR1);
    assign accept    = HSEL && HREADY && HTRANS[1] && HREADYOUT;

`ifdef AHB_SLAVE_ERR_EN
    localparam logic [`BUS_WIDTH-1:0] MEM_BYTES = `BUS_WIDTH'(MEM_DEPTH * BYTES);
    logic unused_bits;
    assign unused_bits = HTRANS[0];
    assign HRESP       = (state == S_ERR1) || (state == S_ERR2);

    always_comb begin
        addr_err = 1'b0;
        if (HADDR >= MEM_BYTES) addr_err = 1'b1;
        if (32'(HSIZE) > LANE_BITS) addr_err = 1'b1;
        else if ((32'(HADDR[LANE_BITS-1:0]) & ((32'd1 << HSIZE) - 32'd1)) != 32'd0)
            addr_err = 1'b1;
    end
`else
    logic unused_bits;
    assign unused_bits = ^{HTRANS[0], HADDR[`BUS_WIDTH-1:LANE_BITS+IDX_BITS]};
    assign HRESP       = 1'b0;
    assign addr_err    = 1'b0;
`endif

    // A read accepted while the preceding write commits must see the merged word.
    always_comb begin
        wr_mask = lane_mask(off_q, size_q);
        wr_word = mem[idx_q];
        for (int unsigned b = 0; b < BYTES; b++) begin
            if (wr_mask[b]) wr_word[8*b +: 8] = HWDATA[8*b +: 8];
        end
        commit  = (state == S_DONE) && write_q;
        rd_idx  = (state == S_WAIT) ? idx_q : haddr_idx;
        rd_word = (commit && (rd_idx == idx_q)) ? wr_word : mem[rd_idx];
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        rd_load       = 1'b0;
        case (state)
            S_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_next = S_DONE;
                    rd_load    = !write_q;
                end else begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end
            end
            S_ERR1: state_next = S_ERR2;
            default: begin
                if (accept) begin
                    if (addr_err) begin
                        state_next = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_next    = S_WAIT;
                        wait_cnt_next = WS_LOAD;
                    end else begin
                        state_next = S_DONE;
                        rd_load    = !HWRITE;
                    end
                end else begin
                    state_next = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            HRDATA   <= '0;
            idx_q    <= '0;
            off_q    <= '0;
            size_q   <= '0;
            write_q  <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (rd_load) HRDATA <= rd_word;
            if (accept) begin
                idx_q   <= haddr_idx;
                off_q   <= HADDR[LANE_BITS-1:0];
                size_q  <= HSIZE;
                write_q <= HWRITE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit) mem[idx_q] <= wr_word;
    end

endmodule

// File: tb/tb_ahb_lite_slave_mem.sv
// Directed bench for ahb_lite_slave_mem: one instance with no wait states, one with two.
`timescale 1ns/1ps
module tb_ahb_lite_slave_mem;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        hsel0 = 1'b0, hsel2 = 1'b0;
    logic [31:0] haddr = '0, hwdata = '0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd2;
    logic [1:0]  htrans = 2'b00;
    logic [31:0] hrdata0, hrdata2;
    logic        hro0, hro2, hresp0, hresp2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ahb_lite_slave_mem #(.MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
        .clk(clk), .resetn(resetn), .HSEL(hsel0), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HTRANS(htrans), .HREADY(hro0), .HWDATA(hwdata),
        .HRDATA(hrdata0), .HREADYOUT(hro0), .HRESP(hresp0));

    ahb_lite_slave_mem #(.MEM_DEPTH(256), .WAIT_STATES(2)) dut2 (
        .clk(clk), .resetn(resetn), .HSEL(hsel2), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HTRANS(htrans), .HREADY(hro2), .HWDATA(hwdata),
        .HRDATA(hrdata2), .HREADYOUT(hro2), .HRESP(hresp2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Single transfer: address phase, then data phase until the selected slave is ready.
    task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wdata,
                        output logic [31:0] rdata, output int lows,
                        output logic resp_first, output logic resp_last);
        logic done, ro, rs;
        haddr = addr; hwrite = wr; hsize = size; htrans = 2'b10;
        hsel0 = (d == 0); hsel2 = (d == 2);
        @(posedge clk); #1;
        htrans = 2'b00; hsel0 = 1'b0; hsel2 = 1'b0; hwdata = wdata;
        lows = 0; done = 1'b0; rdata = '0; resp_first = 1'b0; resp_last = 1'b0;
        for (int i = 0; i < 32 && !done; i++) begin
            @(negedge clk);
            ro = (d == 0) ? hro0 : hro2;
            rs = (d == 0) ? hresp0 : hresp2;
            if (i == 0) resp_first = rs;
            if (ro) begin
                done = 1'b1;
                rdata = (d == 0) ? hrdata0 : hrdata2;
                resp_last = rs;
            end else begin
                lows++;
            end
            @(posedge clk); #1;
        end
        if (!done) check("xfer_timeout", 32'd0, 32'd1);
    endtask

    logic [31:0] rd;
    int          lows;
    logic        rf, rl;

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hreadyout0", {31'd0, hro0}, 32'd1);
        check("rst_hresp0", {31'd0, hresp0}, 32'd0);
        check("rst_hrdata0", hrdata0, 32'd0);
        check("rst_hreadyout2", {31'd0, hro2}, 32'd1);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Word write then read, no wait states
        xfer(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, rd, lows, rf, rl);
        check("ws0_wr_lows", lows, 0);
        xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, rd, lows, rf, rl);
        check("ws0_rd_data", rd, 32'hDEADBEEF);
        check("ws0_rd_lows", lows, 0);
        check("ws0_rd_resp", {31'd0, rl}, 32'd0);

        // Halfword into upper lanes
        xfer(0, 1'b1, 32'h12, 3'd1, 32'h1234_0000, rd, lows, rf, rl);
        xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, rd, lows, rf, rl);
        check("half_merge", rd, 32'h1234BEEF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("hrdata_hold", hrdata0, 32'h1234BEEF);
        @(posedge clk); #1;

        // Byte write with two wait states
        xfer(2, 1'b1, 32'h10, 3'd2, 32'h11223344, rd, lows, rf, rl);
        check("ws2_wr_lows", lows, 2);
        xfer(2, 1'b1, 32'h13, 3'd0, 32'hAA00_0000, rd, lows, rf, rl);
        check("ws2_byte_lows", lows, 2);
        xfer(2, 1'b0, 32'h10, 3'd2, 32'h0, rd, lows, rf, rl);
        check("ws2_byte_data", rd, 32'hAA223344);
        check("ws2_rd_lows", lows, 2);

        // Back-to-back write then read of the same word
        haddr = 32'h20; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10; hsel0 = 1'b1;
        @(posedge clk); #1;
        hwdata = 32'h5; hwrite = 1'b0;
        @(negedge clk);
        check("b2b_wr_ready", {31'd0, hro0}, 32'd1);
        @(posedge clk); #1;
        htrans = 2'b00; hsel0 = 1'b0; hwdata = 32'h0;
        @(negedge clk);
        check("b2b_rd_data", hrdata0, 32'h0000_0005);
        @(posedge clk); #1;

        // Reset during a write's wait state
        xfer(2, 1'b1, 32'h40, 3'd2, 32'h12345678, rd, lows, rf, rl);
        haddr = 32'h40; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10; hsel2 = 1'b1;
        @(posedge clk); #1;
        htrans = 2'b00; hsel2 = 1'b0; hwdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("rst_mid_wait_low", {31'd0, hro2}, 32'd0);
        resetn = 1'b0;
        #1;
        check("rst_mid_ready", {31'd0, hro2}, 32'd1);
        check("rst_mid_resp", {31'd0, hresp2}, 32'd0);
        check("rst_mid_hrdata", hrdata2, 32'd0);
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        xfer(2, 1'b0, 32'h40, 3'd2, 32'h0, rd, lows, rf, rl);
        check("rst_mid_old_data", rd, 32'h12345678);

        // Out-of-range read
        xfer(0, 1'b1, 32'h0, 3'd2, 32'hCAFEF00D, rd, lows, rf, rl);
        xfer(0, 1'b0, 32'h400, 3'd2, 32'h0, rd, lows, rf, rl);
`ifdef AHB_SLAVE_ERR_EN
        check("err_lows", lows, 1);
        check("err_resp_first", {31'd0, rf}, 32'd1);
        check("err_resp_last", {31'd0, rl}, 32'd1);
`else
        check("wrap_lows", lows, 0);
        check("wrap_resp", {31'd0, rl}, 32'd0);
        check("wrap_data", rd, 32'hCAFEF00D);
`endif

        // BUSY transfers are ignored
        haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b01; hsel0 = 1'b1;
        hwdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("busy_ready", {31'd0, hro0}, 32'd1);
            check("busy_resp", {31'd0, hresp0}, 32'd0);
            @(posedge clk); #1;
        end
        htrans = 2'b00; hsel0 = 1'b0;
        xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, rd, lows, rf, rl);
        check("busy_mem_intact", rd, 32'h1234BEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/ahb_lite_slave_mem.md
AHB_LITE_SLAVE_MEM -- requirements
Module: ahb_lite_slave_mem

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, meaning the number of `BUS_WIDTH-bit words in the memory (power of two).
REQ-002 SHALL have parameter WAIT_STATES, default 0, meaning HREADYOUT-low cycles inserted per data phase (0..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port HSEL, input, 1 bit: slave select.
REQ-006 SHALL have port HADDR, input, `BUS_WIDTH bits: byte address.
REQ-007 SHALL have port HWRITE, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port HSIZE, input, 3 bits: transfer size, 2^HSIZE bytes.
REQ-009 SHALL have port HTRANS, input, 2 bits: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-010 SHALL have port HREADY, input, 1 bit: bus-level ready from the interconnect.
REQ-011 SHALL have port HWDATA, input, `BUS_WIDTH bits: write data.
REQ-012 SHALL have port HRDATA, output, `BUS_WIDTH bits: read data.
REQ-013 SHALL have port HREADYOUT, output, 1 bit: this slave's data-phase completion.
REQ-014 SHALL have port HRESP, output, 1 bit: 0 = OKAY, 1 = ERROR.

Function
REQ-015 SHALL accept an address phase only when HSEL=1, HREADY=1 and HTRANS[1]=1; it SHALL register HADDR, HWRITE and HSIZE on that edge.
REQ-016 SHALL treat IDLE and BUSY transfers, and any cycle with HSEL=0, as zero-wait OKAY with no memory access.
REQ-017 SHALL implement states IDLE, WAIT, DONE, ERR1, ERR2; IDLE->WAIT on accept when WAIT_STATES>0, else IDLE->DONE; WAIT->DONE after WAIT_STATES cycles; DONE->DONE on a back-to-back accept, else DONE->IDLE.
REQ-018 SHALL drive HREADYOUT=0 in WAIT and ERR1, and 1 in all other states.
REQ-019 SHALL count WAIT cycles with a 4-bit counter loaded with WAIT_STATES-1 on accept and decremented to 0.
REQ-020 SHALL commit a write on the edge where HREADYOUT=1 in DONE, using HWDATA of that cycle and updating only the 2^HSIZE byte lanes selected by HADDR[log2(`BUS_WIDTH/8)-1:0], little-endian.
REQ-021 SHALL present read data on HRDATA in the cycle HREADYOUT=1 in DONE; the full word is returned and unselected lanes hold memory contents.
REQ-022 SHALL form the word index as HADDR[log2(`BUS_WIDTH/8) +: log2(MEM_DEPTH)].
REQ-023 SHALL return the just-written data when a read to the same word immediately follows a write (no stale data).
REQ-024 SHALL hold HRDATA stable between transfers and SHALL not modify memory on reads.

Reset
REQ-025 SHALL, on resetn=0, asynchronously force state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0 and wait counter 0.
REQ-026 SHALL discard any in-flight transfer on reset mid-operation; a pending write SHALL not be committed.
REQ-027 SHALL leave memory contents unchanged by reset.

Configuration
REQ-028 With AHB_SLAVE_ERR_EN defined, the block SHALL flag an error when HADDR >= MEM_DEPTH*(`BUS_WIDTH/8), when HSIZE exceeds the bus width, or when HADDR is unaligned to HSIZE.
REQ-029 With AHB_SLAVE_ERR_EN defined, a flagged transfer SHALL enter ERR1 (HREADYOUT=0, HRESP=1) and then ERR2 (HREADYOUT=1, HRESP=1), skip wait states and not access memory.
REQ-030 Without AHB_SLAVE_ERR_EN, the block SHALL keep HRESP=0 permanently, wrap addresses modulo the memory size, and align unaligned addresses down to HSIZE.

Verification (`BUS_WIDTH=32, MEM_DEPTH=256)
REQ-031 SHALL cover: WAIT_STATES=0, write word 0xDEADBEEF to 0x10, then read 0x10 -> HRDATA=0xDEADBEEF, HREADYOUT never low.
REQ-032 SHALL cover: WAIT_STATES=2, write byte 0xAA to 0x13 over word 0x11223344 -> read returns 0xAA223344; exactly 2 HREADYOUT-low cycles per transfer.
REQ-033 SHALL cover: back-to-back NONSEQ write 0x5 to 0x20 then read 0x20 -> HRDATA=0x00000005 in the following data phase.
REQ-034 SHALL cover: resetn pulsed low during the WAIT state of a write to 0x40 -> HREADYOUT=1, HRESP=0, and a later read of 0x40 returns the old value.
REQ-035 SHALL cover: with AHB_SLAVE_ERR_EN, read from 0x400 -> one cycle of HREADYOUT=0/HRESP=1 then one of HREADYOUT=1/HRESP=1; without it -> OKAY and the data of 0x000.
REQ-036 SHALL cover: HTRANS=BUSY with HSEL=1 -> HREADYOUT=1, HRESP=0, memory unchanged.
